// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types, including the instruction cache geometry and frame layout
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_SETS  = 8;
    localparam int ICACHE_WORDS = 2;

    typedef struct packed {
        logic [25:0] tag;
        logic [2:0]  idx;
        logic        blkoff;
        logic [1:0]  bytoff;
    } icachef_t;

    typedef struct {
        logic        valid;
        logic [25:0] tag;
        word_t       data [ICACHE_WORDS];
    } icache_frame_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL0,
        FILL1
    } icache_state_t;

endpackage

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache, 8 sets of two-word blocks, same-cycle hits
module icache
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    icache_frame_t r_frames [ICACHE_SETS];
    icache_state_t r_state;
    icache_state_t w_next;
    logic [25:0]   r_miss_tag;
    logic [2:0]    r_miss_idx;
    icachef_t      w_addr;
    logic          w_hit;
    logic          w_unused;

    assign w_addr   = imemaddr;
    assign w_unused = &{1'b0, w_addr.bytoff};

    // Hit detection, next state and Moore memory request; fetch address only feeds the hit path
    always_comb begin
        w_hit    = 1'b0;
        w_next   = r_state;
        iREN     = 1'b0;
        iaddr    = '0;
        imemload = r_frames[w_addr.idx].data[w_addr.blkoff];
        case (r_state)
            FILL0: begin
                iREN  = 1'b1;
                iaddr = {r_miss_tag, r_miss_idx, 1'b0, 2'b00};
                if (!iwait) w_next = FILL1;
            end
            FILL1: begin
                iREN  = 1'b1;
                iaddr = {r_miss_tag, r_miss_idx, 1'b1, 2'b00};
                if (!iwait) w_next = IDLE;
            end
            default: begin
                w_hit = imemREN && r_frames[w_addr.idx].valid && r_frames[w_addr.idx].tag == w_addr.tag;
                if (imemREN && !w_hit) w_next = FILL0;
            end
        endcase
        ihit = w_hit;
    end

    // Frame array, fill FSM and miss latch; a started fill always runs to completion
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_miss_tag <= '0;
            r_miss_idx <= '0;
            for (int i = 0; i < ICACHE_SETS; i++) begin
                r_frames[i].valid   <= 1'b0;
                r_frames[i].tag     <= '0;
                r_frames[i].data[0] <= '0;
                r_frames[i].data[1] <= '0;
            end
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && imemREN && !w_hit) begin
                r_miss_tag <= w_addr.tag;
                r_miss_idx <= w_addr.idx;
            end
            if (r_state == FILL0 && !iwait) r_frames[r_miss_idx].data[0] <= iload;
            if (r_state == FILL1 && !iwait) begin
                r_frames[r_miss_idx].data[1] <= iload;
                r_frames[r_miss_idx].tag     <= r_miss_tag;
                r_frames[r_miss_idx].valid   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_icache.sv
// tb_icache: scoreboard bench for icache against a behavioural memory with programmable wait states
module tb_icache;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = '0;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait = 1'b0;
    logic [31:0] iload;

    int    n_chk = 0;
    int    n_pass = 0;
    word_t exp_q [$];

    icache dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload)
    );

    always #5 CLK = ~CLK;

    function automatic word_t mem_word(input logic [31:0] a);
        if (a[31:2] == 30'h10) return 32'hAAAA0000;
        if (a[31:2] == 30'h11) return 32'hBBBB0001;
        return {~a[15:0], a[15:0]};
    endfunction

    assign iload = mem_word(iaddr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Called just after a falling edge; runs until ihit, checking fill addresses and latency
    task automatic fetch(input logic [31:0] a, input int lat, input int w0, input int w1);
        int    n = 0;
        int    c0 = 0;
        int    c1 = 0;
        int    ph = 0;
        bit    done = 0;
        word_t e;
        exp_q.push_back(mem_word(a));
        imemREN  = 1'b1;
        imemaddr = a;
        while (!done && n < 40) begin
            iwait = iREN && (ph == 0 ? c0 < w0 : c1 < w1);
            #1;
            if (ihit) done = 1;
            else begin
                if (iREN) begin
                    check("fill_iaddr", iaddr, {a[31:3], ph[0], 2'b00});
                    if (iwait) begin
                        if (ph == 0) c0++;
                        else c1++;
                    end else ph++;
                end
                @(negedge CLK);
                n++;
            end
        end
        iwait = 1'b0;
        check("hit", 32'(done), 32'd1);
        check("latency", n, lat);
        e = exp_q.pop_front();
        check("imemload", imemload, e);
        if (done) check("iren_on_hit", 32'(iREN), 32'd0);
    endtask

    initial begin
        nRST = 1'b0;
        imemREN = 1'b1;
        imemaddr = 32'h0;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check("rst_ihit", 32'(ihit), 32'd0);
        check("rst_iren", 32'(iREN), 32'd0);
        check("rst_iaddr", iaddr, 32'h0);
        check("rst_imemload", imemload, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        fetch(32'h0, 3, 0, 0);
        fetch(32'h44, 3, 0, 0);
        fetch(32'h40, 0, 0, 0);
        fetch(32'h1040, 3, 0, 0);
        fetch(32'h40, 3, 0, 0);
        fetch(32'h44, 0, 0, 0);
        fetch(32'h208, 10, 5, 2);
        fetch(32'h20C, 0, 0, 0);
        // address switches to 0x100 while the 0x80 fill is in FILL0
        @(negedge CLK);
        imemREN = 1'b1;
        imemaddr = 32'h80;
        #1;
        check("sw_t0_ihit", 32'(ihit), 32'd0);
        @(negedge CLK);
        #1;
        check("sw_t1_iren", 32'(iREN), 32'd1);
        check("sw_t1_iaddr", iaddr, 32'h80);
        imemaddr = 32'h100;
        @(negedge CLK);
        #1;
        check("sw_t2_iaddr", iaddr, 32'h84);
        @(negedge CLK);
        #1;
        check("sw_t3_ihit", 32'(ihit), 32'd0);
        check("sw_t3_iren", 32'(iREN), 32'd0);
        check("sw_t3_old_word", imemload, mem_word(32'h80));
        fetch(32'h100, 3, 0, 0);
        // reset pulse during FILL1 of 0xC0
        @(negedge CLK);
        imemaddr = 32'hC0;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check("rf_fill1_iaddr", iaddr, 32'hC4);
        nRST = 1'b0;
        #1;
        check("rf_iren", 32'(iREN), 32'd0);
        check("rf_ihit", 32'(ihit), 32'd0);
        check("rf_iaddr", iaddr, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        fetch(32'hC0, 3, 0, 0);
        fetch(32'h20C, 3, 0, 0);
        fetch(32'h208, 0, 0, 0);
        imemREN = 1'b0;
        @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the pipelined datapath's fetch stage and the memory controller. It returns hits to fetch in the same cycle. On a miss it fills a two-word block from memory through a small state machine, holding `ihit` low until the block is resident. Eight sets, two 32-bit words per block: 64 bytes of instruction storage.

## Interface
Parameters:
- none; geometry is fixed by the package constants `ICACHE_SETS` = 8 and `ICACHE_WORDS` = 2.

Ports:
- `CLK`  in  1  clock; reset `nRST`, asynchronous, active-low.
- `nRST`  in  1  asynchronous active-low reset.
- `imemREN`  in  1  fetch read request.
- `imemaddr`  in  32  fetch byte address; low 2 bits ignored.
- `ihit`  out  1  requested word valid on `imemload` this cycle.
- `imemload`  out  32  instruction word.
- `iREN`  out  1  memory read request.
- `iaddr`  out  32  memory word address; low 2 bits always 0.
- `iwait`  in  1  memory busy; `iload` is valid when `iREN` is high and `iwait` is low.
- `iload`  in  32  memory read data.

## Operation
- Address split: tag = `[31:6]` (26 bits), index = `[5:3]`, block offset = `[2]`, byte offset = `[1:0]`.
- Frame contents: `valid`, tag, and 2 data words.
- Hit condition: `imemREN` high, frame valid, and tag equal in state IDLE. Then `ihit` = 1 and `imemload` = `data[index][blkoff]`.
- `imemload` always shows the selected frame word, even when `ihit` = 0.
- State IDLE:
  - `iREN` = 0 and `iaddr` = 0.
  - On `imemREN` and not hit: latch the miss tag and index into `miss_tag` and `miss_idx`, then go to FILL0.
- State FILL0:
  - `iREN` = 1 and `iaddr` = {`miss_tag`, `miss_idx`, 1'b0, 2'b00}.
  - On `!iwait`: write `iload` to `data[miss_idx][0]`, then go to FILL1.
- State FILL1:
  - Same as FILL0 with block offset 1.
  - On `!iwait`: write word 1, write the tag, set `valid`, then go to IDLE.
- `ihit` is forced to 0 in FILL0 and FILL1.
- A fill always completes once started. Dropping `imemREN` or changing `imemaddr` mid-fill does not abort it. The filled block is still installed, and the new address is looked up when the cache returns to IDLE.
- A fill overwrites the previous occupant of `miss_idx` unconditionally. `valid` is unaffected until the end of FILL1, so the old frame stays readable but is not hit-eligible during the fill because `ihit` is gated by state.
- There is no invalidate or flush port; contents persist until reset.

## Timing
- Reset values:
  - `valid` = 0 for all sets; tags and data = 0.
  - State = IDLE; `miss_tag` and `miss_idx` = 0.
  - Outputs: `iREN` = 0, `iaddr` = 0, `ihit` = 0, `imemload` = 0.
- Hit latency is 0 cycles (combinational from `imemaddr`).
- Miss timing, detected in cycle T0:
  - `iREN` is asserted from T1.
  - With zero-wait memory, word 0 is captured at the end of T1 and word 1 at the end of T2.
  - `ihit` = 1 at T3, a 3-cycle penalty.
  - Each `iwait` cycle adds one cycle.
- `iREN`/`iaddr` are Moore outputs, a function of state and the latched miss registers only. They never depend on `imemaddr` combinationally.
- `nRST` asserted mid-fill returns the FSM to IDLE immediately. Partial data is discarded and all `valid` bits are cleared.

## Structure
- Add to the shared `cpu_types_pkg`:
  - `icachef_t`, a packed struct {tag 26, idx 3, blkoff 1, bytoff 2}.
  - `icache_frame_t`, a struct {valid, tag[25:0], `word_t` data[2]}.
  - `icache_state_t`, an enum {IDLE, FILL0, FILL1}.
  - Constants `ICACHE_SETS` and `ICACHE_WORDS`.
- Single module; no sub-module. Frame array, FSM register and miss latch are in one `always_ff`; hit logic and outputs are in `always_comb`.

## Test plan
- Reset with `imemREN` = 1 and `imemaddr` = 0: `ihit` = 0 and `iREN` = 0 during reset. After release, FILL0 requests `iaddr` 0x0, then FILL1 requests 0x4.
- Cold miss at 0x00000044 with zero-wait memory returning 0xAAAA0000 and 0xBBBB0001: `ihit` rises at T3 with `imemload` = 0xBBBB0001. Address 0x40 then hits with 0xAAAA0000 and no `iREN`.
- Conflict: after filling 0x40, request 0x00001040 (same index 0, different tag). A miss refills; re-requesting 0x40 misses again.
- `iwait` held high for 5 cycles in FILL0 and 2 cycles in FILL1: `iaddr` stays stable and `ihit` first asserts 10 cycles after the miss.
- `imemaddr` changes from 0x80 to 0x100 during FILL0: the 0x80 block completes and becomes valid, then 0x100 starts a new fill.
- `nRST` pulsed during FILL1 of 0xC0: the FSM returns to IDLE and the next request to 0xC0 misses.
